ad_ip_jesd204_tpl_dac_fifo: RTL and testbench

Elastic buffer between the transmit DMA stream and the TPL DAC core. It accepts DMA words under a valid/ready handshake, holds them until a programmable prefill level is reached, then drives one word per cycle into the core's `dac_ddata` whenever the core asserts `dac_valid`. Underflow is detected, flagged and counted, and the buffer re-primes automatically. A sync request from the core's sync path flushes the buffer.

---
 rtl/ad_ip_jesd204_tpl_dac_pkg.sv | 13 +
 rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv | 25 ++
 rtl/ad_ip_jesd204_tpl_dac_fifo.sv | 143 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the TPL DAC transmit FIFO: the FIFO state type and
// the width of the underflow event counter.
package ad_ip_jesd204_tpl_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } fifo_state_t;

  localparam int UNDERFLOW_CNT_WIDTH = 16;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
module ad_ip_jesd204_tpl_dac_fifo_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port.
  // NOTE: the storage array has no reset; the FIFO level decides which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Elastic buffer between the transmit DMA stream and the TPL DAC core.
// Accepts DMA words on a valid/ready handshake, waits for PREFILL_LEVEL words,
// then feeds one word per dac_valid cycle into dac_ddata. Underflow zeroes the
// output, raises a sticky flag and re-primes; dac_sync flushes the buffer.
// Build option: AD_TPL_DAC_FIFO_UNDERFLOW_CNT_EN builds the 16-bit saturating
// underflow counter; otherwise underflow_cnt is tied to zero.
module ad_ip_jesd204_tpl_dac_fifo
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DMA_DATA_WIDTH  = 128,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PREFILL_LEVEL   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           dac_sync,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DMA_DATA_WIDTH-1:0]      s_data,
  input  logic                           dac_valid,
  output logic [DMA_DATA_WIDTH-1:0]      dac_ddata,
  output logic [FIFO_ADDR_WIDTH:0]       fill_level,
  output logic                           running,
  output logic                           underflow,
  input  logic                           underflow_clr,
  output logic [UNDERFLOW_CNT_WIDTH-1:0] underflow_cnt
);

  localparam int                   DEPTH       = 2**FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_LVL   = (FIFO_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0] PREFILL_LVL = (FIFO_ADDR_WIDTH+1)'(PREFILL_LEVEL);

  fifo_state_t                state_q, state_nxt;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   level_q, level_nxt;
  logic [DMA_DATA_WIDTH-1:0]  rd_data;
  logic                       push, wr_en, pop, flush, uf_event;

  ad_ip_jesd204_tpl_dac_fifo_mem #(
    .DATA_WIDTH (DMA_DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) i_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Next state, pop/underflow decisions and next level; flushes beat traffic.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state_q;
    flush     = 1'b0;
    pop       = 1'b0;
    uf_event  = 1'b0;
    push      = s_valid && s_ready;
    if (!enable) begin
      state_nxt = ST_IDLE;
      flush     = 1'b1;
    end else if (dac_sync && state_q != ST_IDLE) begin
      state_nxt = ST_PREFILL;
      flush     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:    state_nxt = ST_PREFILL;
        ST_PREFILL: if (level_q >= PREFILL_LVL) state_nxt = ST_RUN;
        ST_RUN: begin
          if (dac_valid) begin
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              uf_event  = 1'b1;
              state_nxt = ST_PREFILL;
            end
          end
        end
        default:    state_nxt = ST_IDLE;
      endcase
    end
    wr_en = push && !flush;
    if (flush)              level_nxt = '0;
    else if (wr_en && !pop) level_nxt = level_q + 1'b1;
    else if (!wr_en && pop) level_nxt = level_q - 1'b1;
    else                    level_nxt = level_q;
  end

  // State, pointers, level, handshake and output data registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready   <= 1'b0;
      running   <= 1'b0;
      dac_ddata <= '0;
    end else begin
      state_q <= state_nxt;
      level_q <= level_nxt;
      s_ready <= (state_nxt != ST_IDLE) && (level_nxt < DEPTH_LVL);
      running <= (state_nxt == ST_RUN);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (flush || uf_event) dac_ddata <= '0;
      else if (pop)          dac_ddata <= rd_data;
    end
  end

  // Sticky underflow flag; a new underflow wins over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              underflow <= 1'b0;
    else if (uf_event)      underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

`ifdef AD_TPL_DAC_FIFO_UNDERFLOW_CNT_EN
  logic [UNDERFLOW_CNT_WIDTH-1:0] uf_cnt_q;

  // Saturating underflow event counter; a clear with a new event leaves 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          uf_cnt_q <= '0;
    else if (underflow_clr)             uf_cnt_q <= uf_event ? UNDERFLOW_CNT_WIDTH'(1) : '0;
    else if (uf_event && uf_cnt_q != '1) uf_cnt_q <= uf_cnt_q + 1'b1;
  end

  assign underflow_cnt = uf_cnt_q;
`else
  assign underflow_cnt = '0;
`endif

  assign fill_level = level_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Self-checking bench for ad_ip_jesd204_tpl_dac_fifo: directed scenarios
// followed by randomized traffic, all compared against a queue-based model.
module tb_ad_ip_jesd204_tpl_dac_fifo;

  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PL    = 8;

  localparam int M_IDLE    = 0;
  localparam int M_PREFILL = 1;
  localparam int M_RUN     = 2;

  logic          clk = 1'b0;
  logic          reset, enable, dac_sync, s_valid, dac_valid, underflow_clr;
  logic          s_ready, running, underflow;
  logic [DW-1:0] s_data, dac_ddata;
  logic [AW:0]   fill_level;
  logic [15:0]   underflow_cnt;

  ad_ip_jesd204_tpl_dac_fifo #(
    .DMA_DATA_WIDTH  (DW),
    .FIFO_ADDR_WIDTH (AW),
    .PREFILL_LEVEL   (PL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .dac_sync      (dac_sync),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .dac_valid     (dac_valid),
    .dac_ddata     (dac_ddata),
    .fill_level    (fill_level),
    .running       (running),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a word queue plus the visible flags.
  int            m_state;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_ddata;
  bit            m_ready, m_running, m_uf;
  int            m_cnt;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; q.delete(); m_ddata = '0;
    m_ready = 1'b0; m_running = 1'b0; m_uf = 1'b0; m_cnt = 0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs held across it.
  task automatic model_edge();
    bit push, ufe, flush;
    int ns;
    push = s_valid && m_ready;
    ufe = 1'b0; flush = 1'b0; ns = m_state;
    if (!enable) begin
      flush = 1'b1; ns = M_IDLE;
    end else if (dac_sync && m_state != M_IDLE) begin
      flush = 1'b1; ns = M_PREFILL;
    end else begin
      if (m_state == M_IDLE) ns = M_PREFILL;
      else if (m_state == M_PREFILL) begin
        if (q.size() >= PL) ns = M_RUN;
      end else if (dac_valid) begin
        if (q.size() > 0) m_ddata = q.pop_front();
        else begin
          ufe = 1'b1; m_ddata = '0; ns = M_PREFILL;
        end
      end
      if (push) q.push_back(s_data);
    end
    if (flush) begin
      q.delete(); m_ddata = '0;
    end
    if (underflow_clr) begin
      m_uf = 1'b0; m_cnt = 0;
    end
    if (ufe) begin
      m_uf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    m_state   = ns;
    m_ready   = (ns != M_IDLE) && (q.size() < DEPTH);
    m_running = (ns == M_RUN);
  endtask

  task automatic check_all();
    int exp_cnt;
`ifdef AD_TPL_DAC_FIFO_UNDERFLOW_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("s_ready",       DW'(s_ready),       DW'(m_ready));
    check("running",       DW'(running),       DW'(m_running));
    check("fill_level",    DW'(fill_level),    DW'(q.size()));
    check("dac_ddata",     dac_ddata,          m_ddata);
    check("underflow",     DW'(underflow),     DW'(m_uf));
    check("underflow_cnt", DW'(underflow_cnt), DW'(exp_cnt));
  endtask

  // Drive inputs at the falling edge, advance one rising edge, check at the next falling edge.
  task automatic step(input bit en, input bit sync, input bit sv, input logic [DW-1:0] sd,
                      input bit dv, input bit clr);
    enable = en; dac_sync = sync; s_valid = sv; s_data = sd;
    dac_valid = dv; underflow_clr = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int p_dv, p_sv;
    reset = 1'b1; enable = 1'b0; dac_sync = 1'b0; s_valid = 1'b0; s_data = '0;
    dac_valid = 1'b0; underflow_clr = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Prime with 1..8, then drain in order, then underflow.
    step(1, 0, 0, '0, 0, 0);
    for (int i = 1; i <= PL; i++) begin
      step(1, 0, 1, DW'(i), 0, 0);
      check("prefill_level", DW'(fill_level), DW'(i));
    end
    check("running_before", DW'(running), DW'(0));
    step(1, 0, 0, '0, 1, 0);
    check("running_after", DW'(running), DW'(1));
    for (int i = 1; i <= PL; i++) begin
      step(1, 0, 0, '0, 1, 0);
      check("drain_data", dac_ddata, DW'(i));
    end
    step(1, 0, 0, '0, 1, 0);
    check("uf_flag", DW'(underflow), DW'(1));
    check("uf_running", DW'(running), DW'(0));
    check("uf_data", dac_ddata, DW'(0));

    // Fill to DEPTH, then pop and push around the pointer wrap.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, DW'(100 + i), 0, 0);
    check("full_level", DW'(fill_level), DW'(DEPTH));
    check("full_ready", DW'(s_ready), DW'(0));
    step(1, 0, 1, DW'(999), 1, 0);
    check("full_pop", dac_ddata, DW'(100));
    step(1, 0, 1, DW'(200), 1, 0);
    check("pushpop_level", DW'(fill_level), DW'(DEPTH - 1));
    check("pushpop_ready", DW'(s_ready), DW'(1));
    step(1, 0, 1, DW'(201), 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, '0, 1, 0);
    check("wrap_last", dac_ddata, DW'(201));

    // Underflow coinciding with a clear.
    step(1, 0, 0, '0, 1, 1);
    check("clr_uf", DW'(underflow), DW'(1));

    // Sync flush at level 10 in RUN, with a word presented.
    for (int i = 0; i < 11; i++) step(1, 0, 1, rnd_word(), 0, 0);
    step(1, 0, 0, '0, 1, 0);
    check("pre_sync_level", DW'(fill_level), DW'(10));
    step(1, 1, 1, rnd_word(), 1, 0);
    check("sync_level", DW'(fill_level), DW'(0));
    check("sync_data", dac_ddata, DW'(0));
    check("sync_running", DW'(running), DW'(0));

    // Enable drop in RUN.
    for (int i = 0; i < 9; i++) step(1, 0, 1, rnd_word(), 0, 0);
    step(1, 0, 0, '0, 1, 0);
    step(0, 0, 1, rnd_word(), 1, 0);
    check("dis_ready", DW'(s_ready), DW'(0));
    check("dis_level", DW'(fill_level), DW'(0));
    step(1, 0, 0, '0, 0, 0);

    // Asynchronous reset in the middle of a push.
    for (int i = 0; i < 3; i++) step(1, 0, 1, rnd_word(), 0, 1);
    enable = 1'b1; s_valid = 1'b1; s_data = rnd_word();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Randomized traffic with phases biasing toward filling or draining.
    p_dv = 50; p_sv = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        p_dv = 10 + 40 * int'($urandom_range(0, 2));
        p_sv = 100 - p_dv;
      end
      step(($urandom_range(0, 99) >= 1),
           ($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < p_sv),
           rnd_word(),
           ($urandom_range(0, 99) < p_dv),
           ($urandom_range(0, 99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
